// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Purpose:
//   Shares one external memory port between two requesters. Port I is
//   instruction fetch and is read-only. Port D is the data stage and can
//   read or write. The arbiter serves one transaction at a time and holds
//   the memory strobes until the memory returns a response pulse. It then
//   hands the read data and a one-cycle acknowledge back to the port that
//   owned the transaction. If no response arrives, a watchdog ends the
//   transaction with an error flag. When both ports ask at once, they are
//   served round-robin.
//
// Parameters:
//   ADDR_W         address width
//   DATA_W         data width
//   TIMEOUT_CYCLES WAIT cycles before an error-ack (0 disables the watchdog)
//   CNT_W          watchdog counter width (must hold TIMEOUT_CYCLES)
//
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   i_req/i_addr               fetch request and address, held until i_ack
//   i_ack/i_rdata/i_err        fetch done pulse, read data, timeout flag
//   d_req/d_we/d_addr/d_wdata  data request, direction, address, write data
//   d_ack/d_rdata/d_err        data done pulse, read data, timeout flag
//   memory_addr/rden/wren/write_val   memory request side (all registered)
//   memory_read_val/memory_response   memory completion side
//
// Every output comes straight from a flop, so no input has a
// combinational path to any output.

module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] memory_addr,
  output logic              memory_rden,
  output logic              memory_wren,
  output logic [DATA_W-1:0] memory_write_val,
  input  logic [DATA_W-1:0] memory_read_val,
  input  logic              memory_response
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // Port identifiers used for owner and last-grant tracking.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic [ADDR_W-1:0] memoryAddr_q, memoryAddr_d;
  logic              memoryRden_q, memoryRden_d;
  logic              memoryWren_q, memoryWren_d;
  logic [DATA_W-1:0] memoryWriteVal_q, memoryWriteVal_d;
  logic              iAck_q, iAck_d;
  logic [DATA_W-1:0] iRdata_q, iRdata_d;
  logic              iErr_q, iErr_d;
  logic              dAck_q, dAck_d;
  logic [DATA_W-1:0] dRdata_q, dRdata_d;
  logic              dErr_q, dErr_d;

  logic              grantValid;
  logic              grantD;
  logic              grantWrite;
  logic [CNT_W-1:0]  wdogInc;
  logic              timeoutHit;

  // Arbitration: a lone requester always wins. On a tie, the port that
  // was not served last goes next, so neither port can starve the other.
  assign grantValid = (state_q == S_IDLE) && (i_req || d_req);
  assign grantD     = d_req && (!i_req || (lastGrant_q == PORT_I));
  assign grantWrite = grantD && d_we;

  // The watchdog fires on the WAIT cycle where the count would reach the
  // limit. The strobes therefore stay up for exactly TIMEOUT_CYCLES cycles.
  assign wdogInc    = wdog_q + CNT_W'(1);
  assign timeoutHit = (TIMEOUT_CYCLES != 0) && (wdogInc == TIMEOUT_VAL);

  // State and datapath registers. Reset is synchronous. After reset, the
  // last grant points at I, so D wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      owner_q          <= PORT_I;
      lastGrant_q      <= PORT_I;
      wdog_q           <= '0;
      memoryAddr_q     <= '0;
      memoryRden_q     <= 1'b0;
      memoryWren_q     <= 1'b0;
      memoryWriteVal_q <= '0;
      iAck_q           <= 1'b0;
      iRdata_q         <= '0;
      iErr_q           <= 1'b0;
      dAck_q           <= 1'b0;
      dRdata_q         <= '0;
      dErr_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      lastGrant_q      <= lastGrant_d;
      wdog_q           <= wdog_d;
      memoryAddr_q     <= memoryAddr_d;
      memoryRden_q     <= memoryRden_d;
      memoryWren_q     <= memoryWren_d;
      memoryWriteVal_q <= memoryWriteVal_d;
      iAck_q           <= iAck_d;
      iRdata_q         <= iRdata_d;
      iErr_q           <= iErr_d;
      dAck_q           <= dAck_d;
      dRdata_q         <= dRdata_d;
      dErr_q           <= dErr_d;
    end
  end

  // Next-state logic. A response pulse seen outside WAIT is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (grantValid) state_d = S_WAIT;
      S_WAIT: if (memory_response || timeoutHit) state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. Acks default low, so each one is a
  // single-cycle pulse. Everything else holds unless it is updated below.
  always_comb begin
    owner_d          = owner_q;
    lastGrant_d      = lastGrant_q;
    wdog_d           = wdog_q;
    memoryAddr_d     = memoryAddr_q;
    memoryRden_d     = memoryRden_q;
    memoryWren_d     = memoryWren_q;
    memoryWriteVal_d = memoryWriteVal_q;
    iAck_d           = 1'b0;
    iRdata_d         = iRdata_q;
    iErr_d           = iErr_q;
    dAck_d           = 1'b0;
    dRdata_d         = dRdata_q;
    dErr_d           = dErr_q;

    case (state_q)
      S_IDLE: begin
        wdog_d = '0;
        if (grantValid) begin
          owner_d          = grantD ? PORT_D : PORT_I;
          memoryAddr_d     = grantD ? d_addr : i_addr;
          memoryWriteVal_d = grantWrite ? d_wdata : '0;
          memoryRden_d     = !grantWrite;
          memoryWren_d     = grantWrite;
        end
      end

      S_WAIT: begin
        wdog_d = wdogInc;
        // A response wins over a timeout in the same cycle. Writes never
        // touch d_rdata, so it keeps the data of the last read.
        if (memory_response) begin
          memoryRden_d = 1'b0;
          memoryWren_d = 1'b0;
          if (owner_q == PORT_D) begin
            dAck_d = 1'b1;
            dErr_d = 1'b0;
            if (!memoryWren_q) dRdata_d = memory_read_val;
          end else begin
            iAck_d   = 1'b1;
            iErr_d   = 1'b0;
            iRdata_d = memory_read_val;
          end
        end else if (timeoutHit) begin
          memoryRden_d = 1'b0;
          memoryWren_d = 1'b0;
          if (owner_q == PORT_D) begin
            dAck_d = 1'b1;
            dErr_d = 1'b1;
            if (!memoryWren_q) dRdata_d = '0;
          end else begin
            iAck_d   = 1'b1;
            iErr_d   = 1'b1;
            iRdata_d = '0;
          end
        end
      end

      S_ACK: begin
        wdog_d      = '0;
        lastGrant_d = owner_q;
      end

      default: begin
        wdog_d = '0;
      end
    endcase
  end

  assign memory_addr      = memoryAddr_q;
  assign memory_rden      = memoryRden_q;
  assign memory_wren      = memoryWren_q;
  assign memory_write_val = memoryWriteVal_q;
  assign i_ack            = iAck_q;
  assign i_rdata          = iRdata_q;
  assign i_err            = iErr_q;
  assign d_ack            = dAck_q;
  assign d_rdata          = dRdata_q;
  assign d_err            = dErr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. The watchdog limit is set to 4 cycles.
// Each transaction comes from a table of records that holds the request
// and the hand-computed ack latency, read data and error flag. The table
// is followed by hand-written sequences for round-robin arbitration and
// for a reset in the middle of a transaction.

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] memory_addr;
  logic        memory_rden;
  logic        memory_wren;
  logic [31:0] memory_write_val;
  logic [31:0] memory_read_val;
  logic        memory_response;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic        isD;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          respCycle;
    logic [31:0] readVal;
    logic [31:0] expRdata;
    logic        expErr;
    int          expAckCycle;
  } txn_t;

  txn_t vec [0:8];

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_req(i_req),
    .i_addr(i_addr),
    .i_ack(i_ack),
    .i_rdata(i_rdata),
    .i_err(i_err),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_ack(d_ack),
    .d_rdata(d_rdata),
    .d_err(d_err),
    .memory_addr(memory_addr),
    .memory_rden(memory_rden),
    .memory_wren(memory_wren),
    .memory_write_val(memory_write_val),
    .memory_read_val(memory_read_val),
    .memory_response(memory_response)
  );

  // Free-running clock. Its rising edges fall at 5, 15, 25 and so on.
  always #5 clk = ~clk;

  // Hard stop in case a sequence never finishes.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation limit reached, got running, required finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  // Two rules hold on every cycle outside reset: the strobes are never
  // both high, and the two acks are never both high.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("strobe_exclusive", 64'(memory_rden & memory_wren), 64'(0));
      checkOutput("ack_exclusive", 64'(i_ack & d_ack), 64'(0));
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    i_req = 1'b0;
    d_req = 1'b0;
    memory_response = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one transaction from a table record. Inputs change on the
  // falling edge. Outputs are checked on the falling edge, half a cycle
  // after the rising edge that set them.
  task automatic applyStimulus(input txn_t t);
    int   c;
    bit   gotAck;
    logic isWrite;
    isWrite = t.isD & t.we;
    @(negedge clk);
    if (t.isD) begin
      d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
    end else begin
      i_req = 1'b1; i_addr = t.addr;
    end
    @(negedge clk);
    checkOutput("grant_addr", 64'(memory_addr), 64'(t.addr));
    if (isWrite) checkOutput("grant_write_val", 64'(memory_write_val), 64'(t.wdata));
    c = 1;
    gotAck = 1'b0;
    while (!gotAck && c < 40) begin
      checkOutput("wait_rden", 64'(memory_rden), 64'(!isWrite));
      checkOutput("wait_wren", 64'(memory_wren), 64'(isWrite));
      if (c == t.respCycle) begin
        memory_response = 1'b1;
        memory_read_val = t.readVal;
      end
      @(negedge clk);
      memory_response = 1'b0;
      memory_read_val = 32'hBAD0BAD0;
      c++;
      gotAck = t.isD ? d_ack : i_ack;
    end
    checkOutput("ack_seen", 64'(gotAck), 64'(1));
    checkOutput("ack_latency", 64'(c), 64'(t.expAckCycle));
    checkOutput("ack_strobes_low", 64'(memory_rden | memory_wren), 64'(0));
    if (t.isD) begin
      checkOutput("d_rdata", 64'(d_rdata), 64'(t.expRdata));
      checkOutput("d_err", 64'(d_err), 64'(t.expErr));
      d_req = 1'b0;
    end else begin
      checkOutput("i_rdata", 64'(i_rdata), 64'(t.expRdata));
      checkOutput("i_err", 64'(i_err), 64'(t.expErr));
      i_req = 1'b0;
    end
    @(negedge clk);
    checkOutput("ack_single_pulse", 64'(i_ack | d_ack), 64'(0));
  endtask

  initial begin
    int grants;
    int dLeft;
    int iLeft;

    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    memory_read_val = '0; memory_response = 1'b0;

    // Fields: isD, we, addr, wdata, respCycle (0 = never), readVal,
    // expRdata, expErr, expAckCycle. Cycle 1 is the first cycle with the
    // strobe visible. A response driven in cycle k gives an ack in k+1.
    // A timeout gives an ack in cycle 5.
    vec[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4};
    vec[1] = '{1'b1, 1'b1, 32'h80,  32'h12345678, 2, 32'hFFFF0000, 32'hDEADBEEF, 1'b0, 3};
    vec[2] = '{1'b0, 1'b0, 32'h100, 32'h0,        1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2};
    vec[3] = '{1'b0, 1'b0, 32'h104, 32'h0,        0, 32'h0,        32'h0,        1'b1, 5};
    vec[4] = '{1'b0, 1'b0, 32'h108, 32'h0,        2, 32'h11223344, 32'h11223344, 1'b0, 3};
    vec[5] = '{1'b1, 1'b0, 32'h44,  32'h0,        4, 32'h00000055, 32'h00000055, 1'b0, 5};
    vec[6] = '{1'b1, 1'b1, 32'h84,  32'hA0A0A0A0, 0, 32'h0,        32'h00000055, 1'b1, 5};
    vec[7] = '{1'b1, 1'b0, 32'h48,  32'h0,        1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 2};
    vec[8] = '{1'b0, 1'b0, 32'h304, 32'h0,        2, 32'h600DF00D, 32'h600DF00D, 1'b0, 3};

    // After reset, every output is zero.
    doReset();
    @(negedge clk);
    checkOutput("reset_i_ack", 64'(i_ack), 64'(0));
    checkOutput("reset_d_ack", 64'(d_ack), 64'(0));
    checkOutput("reset_i_err", 64'(i_err), 64'(0));
    checkOutput("reset_d_err", 64'(d_err), 64'(0));
    checkOutput("reset_i_rdata", 64'(i_rdata), 64'(0));
    checkOutput("reset_d_rdata", 64'(d_rdata), 64'(0));
    checkOutput("reset_rden", 64'(memory_rden), 64'(0));
    checkOutput("reset_wren", 64'(memory_wren), 64'(0));
    checkOutput("reset_addr", 64'(memory_addr), 64'(0));
    checkOutput("reset_write_val", 64'(memory_write_val), 64'(0));

    // Both ports request from reset and each wants 4 reads. The memory
    // answers on the first WAIT cycle. Grants must go D, I, D, I, ...
    // A requester drops req on its ack and raises it again one cycle later.
    $display("[TB] round-robin arbitration");
    dLeft = 4; iLeft = 4; grants = 0;
    i_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int cyc = 0; cyc < 300 && grants < 8; cyc++) begin
      @(negedge clk);
      memory_response = memory_rden | memory_wren;
      memory_read_val = 32'h5A5A0000 + 32'(cyc);
      if (d_ack || i_ack) begin
        checkOutput("grant_order_is_d", 64'(d_ack), 64'((grants % 2) == 0));
        grants++;
        if (d_ack) begin d_req = 1'b0; dLeft--; end
        else       begin i_req = 1'b0; iLeft--; end
      end else begin
        if (dLeft > 0) d_req = 1'b1;
        if (iLeft > 0) i_req = 1'b1;
      end
    end
    memory_response = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    checkOutput("arb_grant_count", 64'(grants), 64'(8));

    // Directed single-port transactions, starting from a fresh reset.
    $display("[TB] table-driven transactions");
    doReset();
    for (int k = 0; k < 8; k++) applyStimulus(vec[k]);

    // Reset asserted in the middle of WAIT, then a late response pulse.
    $display("[TB] reset during WAIT");
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h300;
    @(negedge clk);
    checkOutput("rst_wait_rden", 64'(memory_rden), 64'(1));
    rst_n = 1'b0;
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("rst_strobes_low", 64'(memory_rden | memory_wren), 64'(0));
    checkOutput("rst_no_ack", 64'(i_ack | d_ack), 64'(0));
    rst_n = 1'b1;
    memory_response = 1'b1;
    memory_read_val = 32'h77;
    @(negedge clk);
    memory_response = 1'b0;
    checkOutput("late_resp_no_ack", 64'(i_ack | d_ack), 64'(0));
    checkOutput("late_resp_rdata", 64'(i_rdata), 64'(0));
    @(negedge clk);
    checkOutput("late_resp_idle", 64'(i_ack | memory_rden | memory_wren), 64'(0));
    applyStimulus(vec[8]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
